lcd_text_seq: RTL and testbench
===============================

Name: lcd_text_seq

Overview:
- Upstream feeder for the DE2-115 character-LCD write engine.
- Holds a 2x16 character frame buffer that other logic writes randomly.
- Emits the HD44780 init sequence once, then refreshes the full screen periodically.
- Output is a stream of 9-bit {RS, data} words over a valid/ready handshake; the downstream timing engine consumes one word per LCD write cycle.

Parameters:
- GAP_CYCLES, 1000, idle clock cycles between the end of one frame and the start of the next (minimum 1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- wr_en  in  1  write strobe into the frame buffer
- wr_addr  in  5  cell address: 0-15 = line 1, 16-31 = line 2
- wr_data  in  8  character code
- clear  in  1  one-cycle pulse; fills the buffer with 0x20 (space)
- out_valid  out  1  out_word holds a word for downstream
- out_word  out  9  bit 8 = RS, bits 7:0 = LCD data/command
- out_ready  in  1  downstream accepts the word this cycle
- init_done  out  1  high once the init sequence has been fully accepted
- frame_done  out  1  one-cycle pulse on the handshake of the last line-2 char

Behaviour:
- Reset state, on a clk edge with rst_n=0:
  - out_valid=0, out_word=0, init_done=0, frame_done=0.
  - All 32 buffer cells = 0x20.
  - FSM -> S_INIT, word index 0, gap counter 0.
- Reset mid-stream drops the current word without completing it. After release, the init sequence is re-sent from its first word.
- Handshake:
  - A transfer occurs on a clk edge with out_valid=1 and out_ready=1.
  - While out_valid=1 and out_ready=0, out_word stays stable.
  - out_valid never drops without a transfer, except on reset.
  - out_word is registered. On a transfer edge the next word is loaded, so back-to-back transfers run with zero bubbles.
  - The first word of each phase appears one cycle after entering that phase.
- FSM sequence (word emitted -> next):
  - S_INIT: 0x038, 0x00C, 0x001, 0x006, one per transfer. After the 4th transfer: init_done=1, go to S_FRAME.
  - S_FRAME: 34 words in order:
    - 0x080 (DDRAM line 1)
    - {1'b1, buf[0..15]}
    - 0x0C0 (DDRAM line 2)
    - {1'b1, buf[16..31]}
  - On transfer of word 33: frame_done=1 for one cycle, out_valid=0 the next cycle, go to S_GAP.
  - S_GAP: out_valid=0. Count GAP_CYCLES cycles, then go to S_FRAME at word 0.
- Buffer reads: each buffer cell is sampled when its word is loaded into out_word. A write landing after the load shows up in the next frame.
- Writes:
  - wr_en writes buf[wr_addr] <= wr_data, with no effect on the handshake.
  - Writes are accepted in every state, including during reset release.
  - wr_data is passed through unchanged; no filtering of non-printable codes.
- clear:
  - clear and wr_en in the same cycle: clear wins and the write is discarded.
  - clear does not restart the current frame.
- init_done stays 1 until reset.
- Word counter wraps only via the FSM; no state is reachable outside the 4 init + 34 frame + gap states.

Optional Feature:
- Macro: LCD_DIRTY_EN.
- Defined:
  - A dirty flag is set by any wr_en or clear and is cleared when S_FRAME word 0 is loaded.
  - After the GAP_CYCLES count, S_GAP waits until dirty=1 before entering S_FRAME.
  - The first frame after init is always sent.
  - A write during a frame sets dirty, so exactly one more frame follows.
- Not defined: continuous refresh as described above; no dirty logic is synthesised.

Test Plan:
1. Reset release, out_ready=1 constant -> out_word sequence 0x038, 0x00C, 0x001, 0x006, 0x080, then 0x120 x16, 0x0C0, 0x120 x16. init_done rises after the 4th transfer. frame_done pulses once on the 38th transfer.
2. Write "HELLO" to addr 0-4 and 'W' (0x57) to addr 31 before the frame, GAP_CYCLES=8 -> next frame carries 0x148, 0x145, 0x14C, 0x14C, 0x14F at positions 1-5 and 0x157 as the last word. out_valid is low for exactly 8 cycles plus the 1-cycle reload between frames.
3. Random out_ready (about 30% high) -> the word stream is identical to scenario 1, out_word is stable whenever stalled, and there are no dropped or duplicated words.
4. clear asserted together with wr_en to addr 3 -> cell 3 reads 0x20 in the next frame.
5. rst_n low for 1 cycle in the middle of line 2 -> out_valid=0 on the next cycle, then a restart at 0x038 and init_done=0 until re-init. A buffer written before the reset reads back as spaces.
6. LCD_DIRTY_EN defined, no writes after the first frame -> out_valid stays 0 for 10×GAP_CYCLES. A single wr_en then triggers exactly one 34-word frame.

Source files
------------

// File: rtl/lcd_text_seq.sv
// lcd_text_seq: init + periodic 2x16 refresh word feeder for an HD44780 write engine.
// Latency: first word of a phase is valid one cycle after entering it; back-to-back within a phase.
// Backpressure: out_word/out_valid hold while out_ready=0; buffer writes are never stalled.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   wr_en/wr_addr/wr_data random write port into the 32-cell character buffer
//   clear                 one-cycle pulse, fills buffer with spaces (beats wr_en)
//   out_valid/out_word/out_ready  {RS,data} stream to the LCD timing engine
//   init_done             sticky once the four init commands are accepted
//   frame_done            one-cycle pulse after the last line-2 character is accepted
//
// Optional macro LCD_DIRTY_EN: refresh only when the buffer changed since the last frame.
module lcd_text_seq #(
  parameter int GAP_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       clear,
  output logic       out_valid,
  output logic [8:0] out_word,
  input  logic       out_ready,
  output logic       init_done,
  output logic       frame_done
);

  typedef enum logic [1:0] {
    S_INIT,
    S_FRAME,
    S_GAP
  } state_t;

  localparam int            GW        = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
  localparam logic [5:0]    INIT_LAST = 6'd3;
  localparam logic [5:0]    FRM_LAST  = 6'd33;

  state_t        state_q, state_d;
  logic [5:0]    idx_q, idx_d;          // index of the word currently held in out_word
  logic [GW-1:0] gap_q, gap_d;
  logic          vld_q, vld_d;
  logic [8:0]    word_q, word_d;
  logic          init_done_q, init_done_d;
  logic          frame_done_q, frame_done_d;
  logic [7:0]    cell_q [32];

`ifdef LCD_DIRTY_EN
  logic          dirty_q, dirty_d;
`endif

  logic          xfer;
  logic [5:0]    load_idx;
  logic [4:0]    rd_addr;
  logic [8:0]    init_word;
  logic [8:0]    frame_word;
  logic          gap_go;

  // Word to load: on a transfer the successor of the held word, otherwise the held index itself
  // (used when out_valid is low at the start of a phase).
  always_comb begin
    xfer     = vld_q & out_ready;
    load_idx = xfer ? (idx_q + 6'd1) : idx_q;
  end

  always_comb begin
    init_word = 9'h038;
    case (load_idx[1:0])
      2'd0: init_word = 9'h038;   // 8-bit bus, 2 lines, 5x8 font
      2'd1: init_word = 9'h00C;   // display on, cursor off
      2'd2: init_word = 9'h001;   // clear display
      2'd3: init_word = 9'h006;   // entry mode: increment, no shift
      default: init_word = 9'h038;
    endcase
  end

  // Frame layout: 0 = line-1 address, 1..16 = line-1 chars, 17 = line-2 address, 18..33 = line-2 chars.
  always_comb begin
    rd_addr    = 5'd0;
    frame_word = 9'h080;
    if (load_idx == 6'd0) begin
      frame_word = 9'h080;
    end else if (load_idx <= 6'd16) begin
      rd_addr    = 5'(load_idx - 6'd1);
      frame_word = {1'b1, cell_q[rd_addr]};
    end else if (load_idx == 6'd17) begin
      frame_word = 9'h0C0;
    end else begin
      rd_addr    = 5'(load_idx - 6'd2);
      frame_word = {1'b1, cell_q[rd_addr]};
    end
  end

  always_comb begin
`ifdef LCD_DIRTY_EN
    gap_go = (gap_q == GAP_LAST) && dirty_q;
`else
    gap_go = (gap_q == GAP_LAST);
`endif
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    gap_d        = gap_q;
    vld_d        = vld_q;
    word_d       = word_q;
    init_done_d  = init_done_q;
    frame_done_d = 1'b0;
`ifdef LCD_DIRTY_EN
    dirty_d      = dirty_q;
`endif

    case (state_q)
      S_INIT: begin
        if (xfer && idx_q == INIT_LAST) begin
          init_done_d = 1'b1;
          state_d     = S_FRAME;
          idx_d       = 6'd0;
          vld_d       = 1'b0;
        end else if (xfer || !vld_q) begin
          vld_d  = 1'b1;
          word_d = init_word;
          idx_d  = load_idx;
        end
      end
      S_FRAME: begin
        if (xfer && idx_q == FRM_LAST) begin
          frame_done_d = 1'b1;
          vld_d        = 1'b0;
          state_d      = S_GAP;
          gap_d        = '0;
          idx_d        = 6'd0;
        end else if (xfer || !vld_q) begin
          vld_d  = 1'b1;
          word_d = frame_word;
          idx_d  = load_idx;
`ifdef LCD_DIRTY_EN
          if (load_idx == 6'd0) dirty_d = 1'b0;
`endif
        end
      end
      S_GAP: begin
        vld_d = 1'b0;
        if (gap_go) begin
          state_d = S_FRAME;
          idx_d   = 6'd0;
        end else if (gap_q != GAP_LAST) begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: begin
        state_d = S_INIT;
        idx_d   = 6'd0;
        vld_d   = 1'b0;
      end
    endcase

`ifdef LCD_DIRTY_EN
    // A write coinciding with the word-0 load must still schedule another frame.
    if (wr_en || clear) dirty_d = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_INIT;
      idx_q        <= 6'd0;
      gap_q        <= '0;
      vld_q        <= 1'b0;
      word_q       <= 9'h000;
      init_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef LCD_DIRTY_EN
      dirty_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      gap_q        <= gap_d;
      vld_q        <= vld_d;
      word_q       <= word_d;
      init_done_q  <= init_done_d;
      frame_done_q <= frame_done_d;
`ifdef LCD_DIRTY_EN
      dirty_q      <= dirty_d;
`endif
    end
  end

  // Character buffer: clear beats a same-cycle write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) cell_q[i] <= 8'h20;
    end else if (clear) begin
      for (int i = 0; i < 32; i++) cell_q[i] <= 8'h20;
    end else if (wr_en) begin
      cell_q[wr_addr] <= wr_data;
    end
  end

  assign out_valid  = vld_q;
  assign out_word   = word_q;
  assign init_done  = init_done_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_text_seq.sv
module tb_lcd_text_seq;

  localparam int GAP = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       clear;
  logic       out_valid;
  logic [8:0] out_word;
  logic       out_ready;
  logic       init_done;
  logic       frame_done;

  lcd_text_seq #(.GAP_CYCLES(GAP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .clear     (clear),
    .out_valid (out_valid),
    .out_word  (out_word),
    .out_ready (out_ready),
    .init_done (init_done),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [8:0] q[$];
  logic [7:0] mb[32];
  bit         armed = 0;
  int         xfer_total = 0;
  bit         fd_exp = 0;
  bit         prev_stall = 0;
  logic [8:0] prev_word = '0;
  int         low_run = 0;
  int         last_gap = 0;
  int         hi_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_init();
    q.push_back(9'h038);
    q.push_back(9'h00C);
    q.push_back(9'h001);
    q.push_back(9'h006);
  endtask

  task automatic push_frame();
    q.push_back(9'h080);
    for (int i = 0; i < 16; i++) q.push_back({1'b1, mb[i]});
    q.push_back(9'h0C0);
    for (int i = 16; i < 32; i++) q.push_back({1'b1, mb[i]});
  endtask

  // One clock cycle. Called just after a negedge with inputs already set for the next posedge;
  // samples outputs in the low phase and returns at the following negedge.
  task automatic cyc();
    logic       xfer;
    logic [8:0] exp_w;
    if (armed) begin
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_word", out_word, prev_word);
      end
      chk("init_done", init_done, (xfer_total >= 4));
      chk("frame_done", frame_done, fd_exp);
      if (out_valid) hi_cnt++;
    end
    xfer = armed && out_valid && out_ready && rst_n;
    if (xfer) begin
      chk("unexpected_word", (q.size() != 0), 1);
      if (q.size() != 0) begin
        exp_w = q.pop_front();
        chk("word", out_word, exp_w);
      end
      fd_exp = (xfer_total >= 4) && (((xfer_total - 4) % 34) == 33);
      xfer_total++;
    end else begin
      fd_exp = 0;
    end
    prev_stall = armed && out_valid && !out_ready && rst_n;
    prev_word  = out_word;
    if (armed && !out_valid) begin
      low_run++;
    end else if (armed && out_valid) begin
      if (low_run > 0) last_gap = low_run;
      low_run = 0;
    end
    if (!rst_n) begin
      xfer_total = 0;
      fd_exp     = 0;
      prev_stall = 0;
    end
    @(negedge clk);
  endtask

  task automatic write(input logic [4:0] a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    mb[a]   = d;
    cyc();
    wr_en   = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int b;
    b = budget;
    while (q.size() > 0 && b > 0) begin
      cyc();
      b--;
    end
    chk(tag, q.size(), 0);
  endtask

  initial begin
    int b;
    rst_n     = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    clear     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 32; i++) mb[i] = 8'h20;
    @(negedge clk);
    cyc();
    cyc();
    armed = 1;
    chk("rst_valid", out_valid, 0);
    chk("rst_word", out_word, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_frame_done", frame_done, 0);

    // 1: init sequence then a frame of spaces, out_ready held high
    rst_n = 1'b1;
    push_init();
    push_frame();
    drain("t1_drain", 200);

    // 2: "HELLO" at 0..4 and 'W' at 31 written in the gap; gap length measured
    write(5'd0, 8'h48);
    write(5'd1, 8'h45);
    write(5'd2, 8'h4C);
    write(5'd3, 8'h4C);
    write(5'd4, 8'h4F);
    write(5'd31, 8'h57);
    push_frame();
    drain("t2_drain", 200);
    chk("t2_gap_len", last_gap, GAP + 1);

    // 3+4: clear with same-cycle write to cell 3, then a frame under random out_ready
    clear   = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 5'd3;
    wr_data = 8'h41;
    cyc();
    clear = 1'b0;
    wr_en = 1'b0;
    for (int i = 0; i < 32; i++) mb[i] = 8'h20;
    push_frame();
    b = 2000;
    while (q.size() > 0 && b > 0) begin
      out_ready = ($urandom_range(0, 99) < 30);
      cyc();
      b--;
    end
    chk("t3_drain", q.size(), 0);
    out_ready = 1'b1;

    // 5: write a cell, then reset in the middle of line 2
    write(5'd5, 8'h41);
    push_frame();
    b = 200;
    while (q.size() > 9 && b > 0) begin
      cyc();
      b--;
    end
    chk("t5_reach_line2", q.size(), 9);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    q.delete();
    for (int i = 0; i < 32; i++) mb[i] = 8'h20;
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_word", out_word, 0);
    chk("t5_rst_init_done", init_done, 0);
    push_init();
    push_frame();
    drain("t5_drain", 200);

`ifdef LCD_DIRTY_EN
    // 6: no writes -> no refresh; one write -> exactly one frame
    hi_cnt = 0;
    for (int i = 0; i < 10 * GAP; i++) cyc();
    chk("t6_idle_valid", hi_cnt, 0);
    write(5'd10, 8'h5A);
    push_frame();
    drain("t6_drain", 300);
    hi_cnt = 0;
    for (int i = 0; i < 4 * GAP; i++) cyc();
    chk("t6_single_frame", hi_cnt, 0);
`else
    // 6: continuous refresh without any writes
    push_frame();
    drain("t6_refresh", 300);
    chk("t6_gap_len", last_gap, GAP + 1);
`endif

    cyc();
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
